// File: rtl/hpm_counter_bank.sv
// Memory-mapped bank of hardware performance counters with tear-free wide reads.
// Optional overflow interrupt (irq_o and the IRQEN register) is built when HPM_OVF_IRQ_EN is defined.
module hpm_counter_bank #(
    parameter int NUM_CNTR = 4,
    parameter int CNTR_W   = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_CNTR-1:0] evt_i,
    input  logic                freeze_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [7:0]          addr_i,
    input  logic [31:0]         wdata_i,
    output logic [31:0]         rdata_o,
    output logic                rvalid_o
`ifdef HPM_OVF_IRQ_EN
    ,
    output logic                irq_o
`endif
);

    localparam int         HI_W        = CNTR_W - 32;
    localparam logic [5:0] NUM_CNTR_W6 = 6'(NUM_CNTR);

    logic [CNTR_W-1:0]   r_cntr   [NUM_CNTR];
    logic [HI_W-1:0]     r_shadow [NUM_CNTR];
    logic                r_gen;
    logic [NUM_CNTR-1:0] r_en;
    logic [NUM_CNTR-1:0] r_ovf;
    logic [31:0]         r_rdata;
    logic                r_rvalid;

    logic [CNTR_W-1:0]   w_cntr_nxt   [NUM_CNTR];
    logic [HI_W-1:0]     w_shadow_nxt [NUM_CNTR];
    logic [NUM_CNTR-1:0] w_ovf_nxt;
    logic [31:0]         w_rdata;

    logic       w_rd;
    logic       w_wr;
    logic       w_is_ctrl;
    logic       w_is_en;
    logic       w_is_ovf;
    logic [5:0] w_cnt_idx;
    logic       w_cnt_hit;
    logic       w_cnt_hi;
    logic       w_clear;
    logic       w_count_ok;
    logic       w_unused_addr;

    assign w_rd       = req_i & ~we_i;
    assign w_wr       = req_i & we_i;
    assign w_is_ctrl  = (addr_i[7:2] == 6'h00);
    assign w_is_en    = (addr_i[7:2] == 6'h01);
    assign w_is_ovf   = (addr_i[7:2] == 6'h02);
    // Counter words start at 0x10, two words (low, high) per counter.
    assign w_cnt_idx  = {1'b0, addr_i[7:3]} - 6'd2;
    assign w_cnt_hit  = (addr_i[7:4] != 4'd0) && (w_cnt_idx < NUM_CNTR_W6);
    assign w_cnt_hi   = addr_i[2];
    assign w_clear    = w_wr & w_is_ctrl & wdata_i[1];
    assign w_count_ok = r_gen & ~freeze_i;
    assign w_unused_addr = ^addr_i[1:0];

`ifdef HPM_OVF_IRQ_EN
    logic                w_is_irqen;
    logic [NUM_CNTR-1:0] r_irqen;
    logic                r_irq;
    assign w_is_irqen = (addr_i[7:2] == 6'h03);
`endif

    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_rdata = '0;
        if (w_is_ctrl) begin
            w_rdata[0] = r_gen;
        end else if (w_is_en) begin
            w_rdata[NUM_CNTR-1:0] = r_en;
        end else if (w_is_ovf) begin
            w_rdata[NUM_CNTR-1:0] = r_ovf;
`ifdef HPM_OVF_IRQ_EN
        end else if (w_is_irqen) begin
            w_rdata[NUM_CNTR-1:0] = r_irqen;
`endif
        end
        for (int i = 0; i < NUM_CNTR; i++) begin
            if (w_cnt_hit && (w_cnt_idx == 6'(i))) begin
                if (w_cnt_hi) begin
                    w_rdata[HI_W-1:0] = r_shadow[i];
                end else begin
                    w_rdata = r_cntr[i][31:0];
                end
            end
        end
    end

    // Next state per counter: CTRL clear beats a word write, which beats an increment.
    always_comb begin
        w_ovf_nxt = r_ovf;
        if (w_wr && w_is_ovf) begin
            w_ovf_nxt = r_ovf & ~wdata_i[NUM_CNTR-1:0];
        end
        for (int i = 0; i < NUM_CNTR; i++) begin
            w_cntr_nxt[i]   = r_cntr[i];
            w_shadow_nxt[i] = r_shadow[i];
            if (w_rd && w_cnt_hit && (w_cnt_idx == 6'(i)) && !w_cnt_hi) begin
                w_shadow_nxt[i] = r_cntr[i][CNTR_W-1:32];
            end
            if (w_wr && w_cnt_hit && (w_cnt_idx == 6'(i))) begin
                if (w_cnt_hi) begin
                    w_cntr_nxt[i][CNTR_W-1:32] = wdata_i[HI_W-1:0];
                end else begin
                    w_cntr_nxt[i][31:0] = wdata_i;
                end
            end else if (evt_i[i] && r_en[i] && w_count_ok) begin
                w_cntr_nxt[i] = r_cntr[i] + CNTR_W'(1);
                // A wrap sets the flag even if the same bit is being cleared this cycle.
                if (&r_cntr[i]) begin
                    w_ovf_nxt[i] = 1'b1;
                end
            end
            if (w_clear) begin
                w_cntr_nxt[i]   = '0;
                w_shadow_nxt[i] = '0;
            end
        end
        if (w_clear) begin
            w_ovf_nxt = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_gen    <= 1'b0;
            r_en     <= '0;
            r_ovf    <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            // NOTE: the counter arrays are flops with software-visible reset values, so they are reset like any other register.
            for (int i = 0; i < NUM_CNTR; i++) begin
                r_cntr[i]   <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
            if (w_wr && w_is_ctrl) begin
                r_gen <= wdata_i[0];
            end
            if (w_wr && w_is_en) begin
                r_en <= wdata_i[NUM_CNTR-1:0];
            end
            r_ovf <= w_ovf_nxt;
            for (int i = 0; i < NUM_CNTR; i++) begin
                r_cntr[i]   <= w_cntr_nxt[i];
                r_shadow[i] <= w_shadow_nxt[i];
            end
        end
    end

`ifdef HPM_OVF_IRQ_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_irqen <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr && w_is_irqen) begin
                r_irqen <= wdata_i[NUM_CNTR-1:0];
            end
            r_irq <= |(r_ovf & r_irqen);
        end
    end

    assign irq_o = r_irq;
`endif

    assign rdata_o  = r_rdata;
    assign rvalid_o = r_rvalid;

endmodule
